// File: rtl/fetch_buffer.sv
// Dual-issue instruction queue between fetch and decode: accepts up to two
// consecutive words per cycle, presents the two oldest. Optional macro: FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr0,
    input  logic [31:0]              in_instr1,
    input  logic                     in_valid0,
    input  logic                     in_valid1,
    output logic                     in_ready,
    output logic [31:0]              out_instr0,
    output logic [31:0]              out_instr1,
    output logic [31:0]              out_pc0,
    output logic [31:0]              out_pc1,
    output logic                     out_valid0,
    output logic                     out_valid1,
    input  logic [1:0]               out_take,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pcMem_q    [DEPTH];
    logic [31:0]   instrMem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] headNext, tailNext;
    logic [1:0]    numWr, numValid, numTake;
    logic          rdValid0, rdValid1;
    logic [31:0]   rdPc0, rdPc1, rdInstr0, rdInstr1;

    assign headNext = head_q + AW'(1);
    assign tailNext = tail_q + AW'(1);
    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign count    = count_q;

    always_comb begin
        rdValid0 = (count_q >= CW'(1));
        rdValid1 = (count_q >= CW'(2));
        rdPc0    = pcMem_q[head_q];
        rdPc1    = pcMem_q[headNext];
        rdInstr0 = instrMem_q[head_q];
        rdInstr1 = instrMem_q[headNext];
`ifdef FETCH_BUFFER_BYPASS_EN
        // Empty buffer: hand the incoming pair straight to decode.
        if (count_q == '0 && !flush && !reset) begin
            rdValid0 = in_ready && in_valid0;
            rdValid1 = in_ready && in_valid0 && in_valid1;
            rdPc0    = in_pc;
            rdPc1    = in_pc + 32'd4;
            rdInstr0 = in_instr0;
            rdInstr1 = in_instr1;
        end
`endif
        out_valid0 = rdValid0;
        out_valid1 = rdValid1;
        out_pc0    = rdValid0 ? rdPc0    : '0;
        out_instr0 = rdValid0 ? rdInstr0 : '0;
        out_pc1    = rdValid1 ? rdPc1    : '0;
        out_instr1 = rdValid1 ? rdInstr1 : '0;
    end

    // Bypassed entries are still written at tail and consumed via head, so
    // only the untaken remainder survives in storage.
    always_comb begin
        numWr    = (in_ready && in_valid0) ? (in_valid1 ? 2'd2 : 2'd1) : 2'd0;
        numValid = {1'b0, rdValid0} + {1'b0, rdValid1};
        numTake  = (out_take > numValid) ? numValid : out_take;
        head_d   = head_q + AW'(numTake);
        tail_d   = tail_q + AW'(numWr);
        count_d  = count_q + CW'(numWr) - CW'(numTake);
        if (reset || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (numWr != 2'd0) begin
                pcMem_q[tail_q]    <= in_pc;
                instrMem_q[tail_q] <= in_instr0;
            end
            if (numWr == 2'd2) begin
                pcMem_q[tailNext]    <= in_pc + 32'd4;
                instrMem_q[tailNext] <= in_instr1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && !flush) begin
            assert (out_take <= numValid)
                else $error("fetch_buffer: out_take %0d exceeds %0d valid outputs", out_take, numValid);
            assert (!(in_valid1 && !in_valid0))
                else $error("fetch_buffer: in_valid1 without in_valid0");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: hand table, wrap stream and random
// traffic compared against a queue-based reference model.
module tb_fetch_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [31:0] in_pc, in_instr0, in_instr1;
    logic        in_valid0, in_valid1;
    logic        in_ready;
    logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
    logic        out_valid0, out_valid1;
    logic [1:0]  out_take;
    logic [3:0]  count;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mPc[$];
    logic [31:0] mInstr[$];
    bit          modelKnown = 0;

    typedef struct {
        bit          rst, fl, v0, v1, chk;
        logic [31:0] pc;
        logic [1:0]  take;
        int          eCount;
        bit          eReady, eV0;
        logic [31:0] ePc0;
    } row_t;

    row_t tbl[$];

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_pc(in_pc), .in_instr0(in_instr0), .in_instr1(in_instr1),
        .in_valid0(in_valid0), .in_valid1(in_valid1), .in_ready(in_ready),
        .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelBypass();
`ifdef FETCH_BUFFER_BYPASS_EN
        return (mPc.size() == 0) && !reset && !flush;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int expValidCnt(input bit v0, input bit v1);
        if (modelBypass()) return v0 ? (v1 ? 2 : 1) : 0;
        return (mPc.size() >= 2) ? 2 : mPc.size();
    endfunction

    task automatic applyStimulus(input bit rst, input bit fl, input logic [31:0] pc,
                                 input logic [31:0] i0, input logic [31:0] i1,
                                 input bit v0, input bit v1, input logic [1:0] tk);
        @(negedge clk);
        reset = rst; flush = fl; in_pc = pc; in_instr0 = i0; in_instr1 = i1;
        in_valid0 = v0; in_valid1 = v1; out_take = tk;
        #1;
    endtask

    // Compare all outputs against the model's view of the current cycle.
    task automatic checkOutput();
        int          sz;
        bit          eReady, eV0, eV1;
        logic [31:0] ePc0, ePc1, eI0, eI1;
        if (!modelKnown) return;
        sz     = mPc.size();
        eReady = (DEPTH - sz) >= 2;
        eV0 = sz >= 1; eV1 = sz >= 2;
        ePc0 = eV0 ? mPc[0] : 32'h0;    eI0 = eV0 ? mInstr[0] : 32'h0;
        ePc1 = eV1 ? mPc[1] : 32'h0;    eI1 = eV1 ? mInstr[1] : 32'h0;
        if (modelBypass()) begin
            eV0 = in_valid0; eV1 = in_valid0 && in_valid1;
            ePc0 = eV0 ? in_pc : 32'h0;          eI0 = eV0 ? in_instr0 : 32'h0;
            ePc1 = eV1 ? in_pc + 32'd4 : 32'h0;  eI1 = eV1 ? in_instr1 : 32'h0;
        end
        checkVal("count", 32'(count), 32'(sz));
        checkVal("in_ready", 32'(in_ready), 32'(eReady));
        checkVal("out_valid0", 32'(out_valid0), 32'(eV0));
        checkVal("out_valid1", 32'(out_valid1), 32'(eV1));
        checkVal("out_pc0", out_pc0, ePc0);
        checkVal("out_pc1", out_pc1, ePc1);
        checkVal("out_instr0", out_instr0, eI0);
        checkVal("out_instr1", out_instr1, eI1);
    endtask

    task automatic modelStep();
        bit rdy;
        rdy = (DEPTH - mPc.size()) >= 2;
        if (reset || flush) begin
            mPc.delete(); mInstr.delete();
            modelKnown = 1;
            return;
        end
        if (rdy && in_valid0) begin
            mPc.push_back(in_pc); mInstr.push_back(in_instr0);
            if (in_valid1) begin
                mPc.push_back(in_pc + 32'd4); mInstr.push_back(in_instr1);
            end
        end
        for (int k = 0; k < int'(out_take); k++) begin
            if (mPc.size() > 0) begin
                void'(mPc.pop_front()); void'(mInstr.pop_front());
            end
        end
    endtask

    task automatic doCycle(input bit rst, input bit fl, input logic [31:0] pc,
                           input bit v0, input bit v1, input logic [1:0] tk);
        applyStimulus(rst, fl, pc, pc ^ 32'hA5A5_0000, (pc + 32'd4) ^ 32'hA5A5_0000, v0, v1, tk);
        checkOutput();
        modelStep();
    endtask

    function automatic row_t mk(bit rst, bit fl, logic [31:0] pc, bit v0, bit v1, logic [1:0] tk,
                                bit chk, int c, bit r, bit ev0, logic [31:0] p0);
        row_t t;
        t.rst = rst; t.fl = fl; t.pc = pc; t.v0 = v0; t.v1 = v1; t.take = tk;
        t.chk = chk; t.eCount = c; t.eReady = r; t.eV0 = ev0; t.ePc0 = p0;
        return t;
    endfunction

    initial begin
        logic [31:0] pcNext, consumeNext;
        int nv;
        bit v0, v1, rdy;
        logic [1:0] tk;

        reset = 1; flush = 0; in_pc = 0; in_instr0 = 0; in_instr1 = 0;
        in_valid0 = 0; in_valid1 = 0; out_take = 0;

        // Expectations describe the outputs seen during each row, before its edge.
        tbl.push_back(mk(1,0,32'h1000,1,1,0, 0, 0,1,0,32'h0));
        tbl.push_back(mk(1,0,32'h1000,1,1,0, 1, 0,1,0,32'h0));
        tbl.push_back(mk(0,0,32'h00,1,1,0,   1, 0,1,0,32'h0));
        tbl.push_back(mk(0,0,32'h08,1,1,0,   1, 2,1,1,32'h0));
        tbl.push_back(mk(0,0,32'h10,1,1,0,   1, 4,1,1,32'h0));
        tbl.push_back(mk(0,0,32'h18,1,1,0,   1, 6,1,1,32'h0));
        tbl.push_back(mk(0,0,32'h20,1,1,0,   1, 8,0,1,32'h0));
        tbl.push_back(mk(0,0,32'h20,0,0,2,   1, 8,0,1,32'h00));
        tbl.push_back(mk(0,0,32'h20,0,0,2,   1, 6,1,1,32'h08));
        tbl.push_back(mk(0,0,32'h20,0,0,2,   1, 4,1,1,32'h10));
        tbl.push_back(mk(0,0,32'h20,0,0,2,   1, 2,1,1,32'h18));
        tbl.push_back(mk(0,0,32'h40,1,0,0,   1, 0,1,0,32'h0));
        tbl.push_back(mk(0,0,32'h40,0,0,0,   1, 1,1,1,32'h40));
        tbl.push_back(mk(0,0,32'h40,0,0,1,   1, 1,1,1,32'h40));
        tbl.push_back(mk(0,0,32'h50,1,1,0,   1, 0,1,0,32'h0));
        tbl.push_back(mk(0,0,32'h58,1,1,0,   1, 2,1,1,32'h50));
        tbl.push_back(mk(0,0,32'h60,1,0,0,   1, 4,1,1,32'h50));
        tbl.push_back(mk(0,1,32'h70,1,1,2,   1, 5,1,1,32'h50));
        tbl.push_back(mk(0,0,32'h100,1,0,0,  1, 0,1,0,32'h0));
        tbl.push_back(mk(0,0,32'h100,0,0,0,  1, 1,1,1,32'h100));
        tbl.push_back(mk(0,0,32'h100,0,0,1,  1, 1,1,1,32'h100));
        tbl.push_back(mk(0,0,32'h100,0,0,0,  1, 0,1,0,32'h0));

`ifndef FETCH_BUFFER_BYPASS_EN
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].fl, tbl[i].pc, tbl[i].pc ^ 32'hA5A5_0000,
                          (tbl[i].pc + 32'd4) ^ 32'hA5A5_0000, tbl[i].v0, tbl[i].v1, tbl[i].take);
            checkOutput();
            if (tbl[i].chk) begin
                checkVal($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].eCount));
                checkVal($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].eReady));
                checkVal($sformatf("tbl%0d.out_valid0", i), 32'(out_valid0), 32'(tbl[i].eV0));
                checkVal($sformatf("tbl%0d.out_pc0", i), out_pc0, tbl[i].ePc0);
            end
            modelStep();
        end
`else
        doCycle(1, 0, 32'h0, 1, 1, 0);
        doCycle(1, 0, 32'h0, 1, 1, 0);
        doCycle(0, 0, 32'h200, 1, 1, 1);
        checkVal("bypass.out_pc0", out_pc0, 32'h200);
        doCycle(0, 0, 32'h0, 0, 0, 0);
        checkVal("bypass.count", 32'(count), 32'd1);
        checkVal("bypass.next_pc0", out_pc0, 32'h204);
        doCycle(0, 1, 32'h0, 0, 0, 0);
`endif

        // Continuous pair stream with alternating takes across pointer wrap.
        doCycle(0, 1, 32'h0, 0, 0, 0);
        pcNext = 32'h1000; consumeNext = 32'h1000;
        for (int i = 0; i < 24; i++) begin
            rdy = (DEPTH - mPc.size()) >= 2;
            nv  = expValidCnt(1, 1);
            tk  = 2'((i % 2 == 0) ? 1 : 2);
            if (int'(tk) > nv) tk = 2'(nv);
            doCycle(0, 0, pcNext, 1, 1, tk);
            if (tk != 0) checkVal("wrap.order", out_pc0, consumeNext);
            consumeNext += 32'(4 * int'(tk));
            if (rdy) pcNext += 32'd8;
        end

        // Randomised traffic including occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            bit rst, fl;
            logic [31:0] pc;
            rst = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 24) == 0);
            v0  = $urandom_range(0, 1);
            v1  = v0 && ($urandom_range(0, 2) != 0);
            pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            applyStimulus(rst, fl, pc, $urandom, $urandom, v0, v1, 2'd0);
            nv = expValidCnt(v0, v1);
            out_take = 2'($urandom_range(0, nv));
            #1;
            checkOutput();
            modelStep();
        end

        doCycle(0, 0, 32'h0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

- Dual-issue instruction queue between the instruction-memory fetch stage and decode.
- Accepts up to two consecutive instruction words per cycle, each tagged with its PC.
- Presents the two oldest entries to decode, which retires 0, 1 or 2 per cycle.
- Absorbs decode stalls and empties on a pipeline redirect (flush).

## Interface

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all stored entries (branch/jump redirect).
- in_pc  in  32  PC of in_instr0; in_instr1 is tagged in_pc+4.
- in_instr0  in  32  instruction word at in_pc.
- in_instr1  in  32  instruction word at in_pc+4.
- in_valid0  in  1  in_instr0 is to be written.
- in_valid1  in  1  in_instr1 is to be written; legal only when in_valid0=1.
- in_ready  out  1  at least 2 free entries this cycle.
- out_instr0 / out_instr1  out  32 each  oldest and second-oldest entry.
- out_pc0 / out_pc1  out  32 each  PCs of those entries.
- out_valid0 / out_valid1  out  1 each  entry present; out_valid1 implies out_valid0.
- out_take  in  2  entries consumed this cycle (0, 1 or 2).
- count  out  log2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation

- Storage is a circular array of DEPTH {pc, instr} entries.
- Head and tail pointers wrap modulo DEPTH; a count register holds occupancy.
- Write is accepted only when in_ready=1. It writes 0, 1 or 2 entries in order (instr0 then instr1) at tail, and tail advances by the number written.
- Offered inputs while in_ready=0 are dropped. The upstream stage must hold its PC when in_ready=0.
- in_ready = (DEPTH - count >= 2). It is computed from the registered count only; same-cycle out_take does not raise it. This keeps in_ready off the out_take combinational path.
- Read: out_* show entries at head and head+1 (wrapped).
  - out_valid0 = (count >= 1).
  - out_valid1 = (count >= 2).
  - Any out_instr/out_pc whose valid bit is 0 drives 0.
- out_take:
  - head advances by out_take.
  - out_take is clamped to the number of valid outputs; a take exceeding that is a protocol error and triggers a simulation assertion.
- Next count = count + written - taken. A simultaneous write and take is always legal.
- flush:
  - Next cycle: count=0 and head=tail=0.
  - Same-cycle writes and takes are ignored; flush has priority.
- reset: same effect as flush. All outputs take their reset values:
  - in_ready=1.
  - out_valid0=out_valid1=0.
  - out_instr*/out_pc* = 0.
  - count=0.
- in_valid1=1 with in_valid0=0 is a protocol error and triggers an assertion. Nothing is written for that cycle.

## Timing

- Write-to-read latency is 1 cycle: an entry written at edge N is visible on out_* after edge N.
- No same-cycle bypass unless FETCH_BUFFER_BYPASS_EN is defined (see Configuration).
- out_* and out_valid* are combinational from registered state only; there is no combinational path from in_* or out_take to out_*.
- in_ready depends on registered count only.
- Throughput is 2 instr/cycle in and out at steady state when count is between 2 and DEPTH-2.
- Full boundary: with count=DEPTH-1, in_ready=0 even though one slot is free.
- Empty boundary: with count=1, out_valid1=0, so decode may take at most 1.
- Pointer wrap: head/tail crossing DEPTH-1 to 0 is seamless, and entry order is preserved across the wrap.

## Configuration

- FETCH_BUFFER_BYPASS_EN defined:
  - When count=0 and flush=0, out_* mirror in_pc/in_instr*/in_valid* combinationally, gated by in_ready.
  - out_take consumes those inputs directly in the same cycle.
  - Only the untaken remainder is written into storage.
  - Empty-buffer latency becomes 0 cycles.
  - This adds a combinational path from in_* to out_*.
- FETCH_BUFFER_BYPASS_EN undefined: behaviour exactly as in Operation/Timing, with a 1-cycle minimum latency.

## Test plan

- Reset: assert reset 2 cycles with in_valid0/1=1 -> count=0, out_valid0/1=0, in_ready=1, out_pc0=0; nothing written.
- Fill/drain: write pairs at in_pc=0x00,0x08,0x10 with out_take=0 -> count=6, in_ready=1. Next pair -> count=8, in_ready=0. Then out_take=2 for 4 cycles -> out_pc0 sequence 0x00,0x08,0x10,0x18, ending with count=0.
- Odd takes and wrap: stream pairs continuously with out_take alternating 1,2 for 20 cycles (DEPTH=8) -> out_pc0 strictly increases by 4 per consumed entry with no gaps or duplicates across pointer wrap.
- Partial write/empty edge: single write in_valid0=1, in_valid1=0, in_pc=0x40 -> next cycle out_valid0=1, out_pc0=0x40, out_valid1=0, count=1.
- Flush priority: count=5, then flush=1 with in_valid0/1=1 and out_take=2 in the same cycle -> next cycle count=0, out_valid0=0. Write at in_pc=0x100 the cycle after -> out_pc0=0x100.
- Bypass (macro defined): count=0, in_pc=0x200, in_valid0/1=1, out_take=1 -> same cycle out_pc0=0x200. Next cycle count=1 with out_pc0=0x204.
